// File: rtl/m68k_arb_pkg.sv
// Shared types and helpers for the 68000 bus arbiter and address decoder.
// FSM state encoding, index-width helper and chip-select codes live here.
package m68k_arb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQUEST  = 3'd1,
        WAIT_BUS = 3'd2,
        OWN      = 3'd3,
        RELEASE  = 3'd4
    } arb_state_t;

    // Chip-select codes; the decoder and arbiter must agree on these.
    localparam logic [2:0] DEV_NONE = 3'd0;
    localparam logic [2:0] DEV_ROM  = 3'd1;
    localparam logic [2:0] DEV_RAM  = 3'd2;
    localparam logic [2:0] DEV_IO   = 3'd3;
    localparam logic [2:0] DEV_DMA  = 3'd4;

    // Width needed to index n items, never less than 1 bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/m68k_rr_pick.sv
// Combinational round-robin picker: first eligible requester after the pointer,
// wrapping modulo NUM_REQ.
module m68k_rr_pick
    import m68k_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    int idx;

    // Scan from farthest to nearest so the nearest hit after ptr wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req[idx]) begin
                valid  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/m68k_bus_arbiter.sv
// Arbitrates the 68000 bus between the CPU (BR/BG/BGACK) and NUM_REQ masters.
// Optional build macro M68K_ARB_TIMEOUT_EN enables the OWN hold timeout.
module m68k_bus_arbiter
    import m68k_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int CPU_GAP  = 4,
    parameter int MAX_HOLD = 256
) (
    input  logic               clk16,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               br_n,
    input  logic               bg_n,
    output logic               bgack_n,
    input  logic               as_n,
    input  logic               dtack_n,
    output logic               busy,
    output logic               hold_err
);

    localparam int REQ_IDX_W = idx_w(NUM_REQ);
    localparam int GAP_W     = idx_w(CPU_GAP + 1);
    localparam logic [GAP_W-1:0]     GAP_INIT = GAP_W'(CPU_GAP);
    localparam logic [REQ_IDX_W-1:0] PTR_INIT = REQ_IDX_W'(NUM_REQ - 1);

    if (NUM_REQ < 1 || NUM_REQ > 8 || MAX_HOLD < 1) begin : g_bad_cfg
        $error("m68k_bus_arbiter: unsupported NUM_REQ or MAX_HOLD");
    end

    arb_state_t           state;
    logic [GAP_W-1:0]     gap_cnt;
    logic [REQ_IDX_W-1:0] ptr;
    logic [REQ_IDX_W-1:0] winner;
    logic [REQ_IDX_W-1:0] pick_idx;
    logic                 pick_vld;
    logic [NUM_REQ-1:0]   eligible;

    logic bg_n_p0, bg_n_s;
    logic as_n_p0, as_n_s;
    logic dtack_n_p0, dtack_n_s;

    // Two-flop synchronisers for the CPU-side asynchronous inputs.
    always_ff @(posedge clk16) begin
        if (reset) begin
            bg_n_p0    <= 1'b1;
            bg_n_s     <= 1'b1;
            as_n_p0    <= 1'b1;
            as_n_s     <= 1'b1;
            dtack_n_p0 <= 1'b1;
            dtack_n_s  <= 1'b1;
        end else begin
            bg_n_p0    <= bg_n;
            bg_n_s     <= bg_n_p0;
            as_n_p0    <= as_n;
            as_n_s     <= as_n_p0;
            dtack_n_p0 <= dtack_n;
            dtack_n_s  <= dtack_n_p0;
        end
    end

`ifdef M68K_ARB_TIMEOUT_EN
    localparam int HOLD_W = idx_w(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0]  hold_cnt;
    logic [NUM_REQ-1:0] blocked;

    assign eligible = req & ~blocked;
`else
    assign eligible = req;
    assign hold_err = 1'b0;
`endif

    m68k_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (REQ_IDX_W)
    ) u_pick (
        .req    (eligible),
        .ptr    (ptr),
        .winner (pick_idx),
        .valid  (pick_vld)
    );

    always_ff @(posedge clk16) begin
        if (reset) begin
            state    <= IDLE;
            br_n     <= 1'b1;
            bgack_n  <= 1'b1;
            gnt      <= '0;
            busy     <= 1'b0;
            gap_cnt  <= '0;
            ptr      <= PTR_INIT;
`ifdef M68K_ARB_TIMEOUT_EN
            hold_err <= 1'b0;
            blocked  <= '0;
`endif
        end else begin
`ifdef M68K_ARB_TIMEOUT_EN
            hold_err <= 1'b0;
            // A blocked requester becomes eligible again once its req is seen low.
            blocked  <= blocked & req;
`endif
            case (state)
                IDLE: begin
                    if (gap_cnt == '0) begin
                        if (pick_vld) begin
                            winner <= pick_idx;
                            state  <= REQUEST;
                            br_n   <= 1'b0;
                            busy   <= 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                REQUEST: begin
                    if (!req[winner]) begin
                        state <= IDLE;
                        br_n  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (!bg_n_s) begin
                        state <= WAIT_BUS;
                    end
                end
                WAIT_BUS: begin
                    if (!req[winner]) begin
                        state <= IDLE;
                        br_n  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (as_n_s && dtack_n_s) begin
                        state    <= OWN;
                        br_n     <= 1'b1;
                        bgack_n  <= 1'b0;
                        gnt      <= NUM_REQ'(1) << winner;
                        ptr      <= winner;
`ifdef M68K_ARB_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end
                end
                OWN: begin
                    if (!req[winner]) begin
                        state <= RELEASE;
                        gnt   <= '0;
`ifdef M68K_ARB_TIMEOUT_EN
                    end else if (hold_cnt == HOLD_LAST) begin
                        state           <= RELEASE;
                        gnt             <= '0;
                        hold_err        <= 1'b1;
                        blocked[winner] <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
`endif
                    end
                end
                RELEASE: begin
                    state   <= IDLE;
                    bgack_n <= 1'b1;
                    busy    <= 1'b0;
                    gap_cnt <= GAP_INIT;
                end
                default: begin
                    state   <= IDLE;
                    br_n    <= 1'b1;
                    bgack_n <= 1'b1;
                    gnt     <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
